// File: rtl/qpu_dtcm_icb_arbiter.sv
// Two-port round-robin arbiter sharing the single DTCM ICB port between the LSU (port 0)
// and the measurement writeback path (port 1); an in-order ID FIFO routes responses back.
module qpu_dtcm_icb_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int OUTS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_cmd_valid,
  output logic            p0_cmd_ready,
  input  logic [AW-1:0]   p0_cmd_addr,
  input  logic            p0_cmd_read,
  input  logic [DW-1:0]   p0_cmd_wdata,
  input  logic [DW/8-1:0] p0_cmd_wmask,
  output logic            p0_rsp_valid,
  input  logic            p0_rsp_ready,
  output logic [DW-1:0]   p0_rsp_rdata,
  input  logic            p1_cmd_valid,
  output logic            p1_cmd_ready,
  input  logic [AW-1:0]   p1_cmd_addr,
  input  logic            p1_cmd_read,
  input  logic [DW-1:0]   p1_cmd_wdata,
  input  logic [DW/8-1:0] p1_cmd_wmask,
  output logic            p1_rsp_valid,
  input  logic            p1_rsp_ready,
  output logic [DW-1:0]   p1_rsp_rdata,
  output logic            dtcm_cmd_valid,
  input  logic            dtcm_cmd_ready,
  output logic [AW-1:0]   dtcm_cmd_addr,
  output logic            dtcm_cmd_read,
  output logic [DW-1:0]   dtcm_cmd_wdata,
  output logic [DW/8-1:0] dtcm_cmd_wmask,
  input  logic            dtcm_rsp_valid,
  output logic            dtcm_rsp_ready,
  input  logic [DW-1:0]   dtcm_rsp_rdata,
  output logic            arb_active,
  output logic            arb_err
);

  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS) + 1;
  localparam logic [CW-1:0] OUTS_C   = CW'(OUTS);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTS - 1);

  logic            prio_r;
  logic            lock_r;
  logic            lock_id_r;
  logic            arb_err_r;
  logic [OUTS-1:0] fifo_r;
  logic [PW-1:0]   wptr_r;
  logic [PW-1:0]   rptr_r;
  logic [CW-1:0]   cnt_r;

  logic grant_vld_s;
  logic grant_id_s;
  logic full_s;
  logic issue_s;
  logic accept_s;
  logic stall_s;
  logic nonempty_s;
  logic head_id_s;
  logic pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PW{1'b0}};
    end else begin
      nxt = ptr + PW'(1);
    end
    return nxt;
  endfunction

  // Grant selection: a stalled command keeps its grant until the DTCM takes it.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (lock_r) begin
      grant_vld_s = 1'b1;
      grant_id_s  = lock_id_r;
    end else if (p0_cmd_valid && p1_cmd_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = prio_r;
    end else if (p0_cmd_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (p1_cmd_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Full blocks issue on the registered count, so a same-cycle pop cannot unblock it.
  assign full_s   = (cnt_r == OUTS_C);
  assign issue_s  = grant_vld_s & ~full_s;
  assign accept_s = issue_s & dtcm_cmd_ready;
  assign stall_s  = issue_s & ~dtcm_cmd_ready;

  assign dtcm_cmd_valid = issue_s;
  assign dtcm_cmd_addr  = grant_id_s ? p1_cmd_addr  : p0_cmd_addr;
  assign dtcm_cmd_read  = grant_id_s ? p1_cmd_read  : p0_cmd_read;
  assign dtcm_cmd_wdata = grant_id_s ? p1_cmd_wdata : p0_cmd_wdata;
  assign dtcm_cmd_wmask = grant_id_s ? p1_cmd_wmask : p0_cmd_wmask;
  assign p0_cmd_ready   = accept_s & ~grant_id_s;
  assign p1_cmd_ready   = accept_s &  grant_id_s;

  assign nonempty_s     = (cnt_r != {CW{1'b0}});
  assign head_id_s      = fifo_r[rptr_r];
  assign p0_rsp_valid   = dtcm_rsp_valid & nonempty_s & ~head_id_s;
  assign p1_rsp_valid   = dtcm_rsp_valid & nonempty_s &  head_id_s;
  assign p0_rsp_rdata   = dtcm_rsp_rdata;
  assign p1_rsp_rdata   = dtcm_rsp_rdata;
  // With nothing outstanding, responses are stray and get drained unconditionally.
  assign dtcm_rsp_ready = nonempty_s ? (head_id_s ? p1_rsp_ready : p0_rsp_ready) : 1'b1;
  assign pop_s          = dtcm_rsp_valid & dtcm_rsp_ready & nonempty_s;

  assign arb_active = p0_cmd_valid | p1_cmd_valid | nonempty_s;
  assign arb_err    = arb_err_r;

  // Round-robin priority, command lock and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r    <= 1'b0;
      lock_r    <= 1'b0;
      lock_id_r <= 1'b0;
      arb_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        prio_r <= ~grant_id_s;
        lock_r <= 1'b0;
      end else if (stall_s) begin
        lock_r    <= 1'b1;
        lock_id_r <= grant_id_s;
      end
      if (dtcm_rsp_valid && !nonempty_s) begin
        arb_err_r <= 1'b1;
      end
    end
  end

  // In-order ID FIFO of outstanding transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_r <= {OUTS{1'b0}};
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        fifo_r[wptr_r] <= grant_id_s;
        wptr_r         <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_qpu_dtcm_icb_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a queue-based model.
module tb_qpu_dtcm_icb_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int OUTS = 2;

  logic clk = 1'b0;
  logic rst;

  logic            p0_cmd_valid, p0_cmd_ready, p0_cmd_read, p0_rsp_valid, p0_rsp_ready;
  logic [AW-1:0]   p0_cmd_addr;
  logic [DW-1:0]   p0_cmd_wdata, p0_rsp_rdata;
  logic [DW/8-1:0] p0_cmd_wmask;
  logic            p1_cmd_valid, p1_cmd_ready, p1_cmd_read, p1_rsp_valid, p1_rsp_ready;
  logic [AW-1:0]   p1_cmd_addr;
  logic [DW-1:0]   p1_cmd_wdata, p1_rsp_rdata;
  logic [DW/8-1:0] p1_cmd_wmask;
  logic            dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [AW-1:0]   dtcm_cmd_addr;
  logic [DW-1:0]   dtcm_cmd_wdata;
  logic [DW/8-1:0] dtcm_cmd_wmask;
  logic            dtcm_rsp_valid, dtcm_rsp_ready;
  logic [DW-1:0]   dtcm_rsp_rdata;
  logic            arb_active, arb_err;

  // Requester-side drive arrays, indexed by port
  logic            req_v  [2];
  logic [AW-1:0]   req_a  [2];
  logic            req_rd [2];
  logic [DW-1:0]   req_wd [2];
  logic [DW/8-1:0] req_wm [2];
  logic            rsp_rdy[2];

  assign p0_cmd_valid = req_v[0];  assign p1_cmd_valid = req_v[1];
  assign p0_cmd_addr  = req_a[0];  assign p1_cmd_addr  = req_a[1];
  assign p0_cmd_read  = req_rd[0]; assign p1_cmd_read  = req_rd[1];
  assign p0_cmd_wdata = req_wd[0]; assign p1_cmd_wdata = req_wd[1];
  assign p0_cmd_wmask = req_wm[0]; assign p1_cmd_wmask = req_wm[1];
  assign p0_rsp_ready = rsp_rdy[0]; assign p1_rsp_ready = rsp_rdy[1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qpu_dtcm_icb_arbiter #(.AW(AW), .DW(DW), .OUTS(OUTS)) dut (
    .clk(clk), .rst(rst),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready), .p0_cmd_addr(p0_cmd_addr),
    .p0_cmd_read(p0_cmd_read), .p0_cmd_wdata(p0_cmd_wdata), .p0_cmd_wmask(p0_cmd_wmask),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready), .p1_cmd_addr(p1_cmd_addr),
    .p1_cmd_read(p1_cmd_read), .p1_cmd_wdata(p1_cmd_wdata), .p1_cmd_wmask(p1_cmd_wmask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
    .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .arb_active(arb_active), .arb_err(arb_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    for (int n = 0; n < 2; n++) begin
      req_v[n]   = 1'b0;
      req_a[n]   = 16'h0000;
      req_rd[n]  = 1'b1;
      req_wd[n]  = 32'h0000_0000;
      req_wm[n]  = 4'h0;
      rsp_rdy[n] = 1'b1;
    end
    dtcm_cmd_ready = 1'b1;
    dtcm_rsp_valid = 1'b0;
    dtcm_rsp_rdata = 32'h0000_0000;
  endtask

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return {a, a ^ 16'h5A5A};
  endfunction

  // Reference model state for the random phase
  int            q_out[$];
  logic [AW-1:0] q_dtcm[$];
  logic [AW-1:0] pq0[$];
  logic [AW-1:0] pq1[$];
  int            prio_m;
  int            lock_m;
  logic          done_v[2];
  logic          rsp_done;

  initial begin
    int g, h;
    logic iss, exp_rr;
    logic [AW-1:0] fa;

    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk1("rst_dtcm_cmd_valid", dtcm_cmd_valid, 1'b0);
    chk1("rst_p0_cmd_ready", p0_cmd_ready, 1'b0);
    chk1("rst_p1_cmd_ready", p1_cmd_ready, 1'b0);
    chk1("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
    chk1("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
    chk1("rst_dtcm_rsp_ready", dtcm_rsp_ready, 1'b1);
    chk1("rst_arb_err", arb_err, 1'b0);
    chk1("rst_arb_active", arb_active, 1'b0);

    // Both ports valid for 4 cycles, responses one cycle later
    for (int i = 0; i <= 4; i++) begin
      tick();
      req_v[0] = (i < 4); req_a[0] = 16'h0010; req_rd[0] = 1'b1;
      req_v[1] = (i < 4); req_a[1] = 16'h0020; req_rd[1] = 1'b1;
      dtcm_rsp_valid = (i > 0);
      dtcm_rsp_rdata = rd_of((i % 2 == 1) ? 16'h0010 : 16'h0020);
      settle();
      if (i < 4) begin
        chk1("rr_cmd_valid", dtcm_cmd_valid, 1'b1);
        chkw("rr_addr", 32'(dtcm_cmd_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
        chk1("rr_p0_cmd_ready", p0_cmd_ready, (i % 2 == 0));
        chk1("rr_p1_cmd_ready", p1_cmd_ready, (i % 2 == 1));
      end
      if (i > 0) begin
        chk1("rr_p0_rsp_valid", p0_rsp_valid, (i % 2 == 1));
        chk1("rr_p1_rsp_valid", p1_rsp_valid, (i % 2 == 0));
        chkw("rr_rsp_rdata", (i % 2 == 1) ? p0_rsp_rdata : p1_rsp_rdata,
             rd_of((i % 2 == 1) ? 16'h0010 : 16'h0020));
      end
    end
    tick(); idle_in(); settle();
    chk1("rr_idle_active", arb_active, 1'b0);

    // p1 write stalled 3 cycles, p0 joins in cycle 2
    for (int i = 0; i <= 4; i++) begin
      tick();
      req_v[1] = (i < 4); req_a[1] = 16'h0008; req_rd[1] = 1'b0;
      req_wd[1] = 32'hDEAD_BEEF; req_wm[1] = 4'hF;
      req_v[0] = (i >= 2); req_a[0] = 16'h0004; req_rd[0] = 1'b1;
      dtcm_cmd_ready = (i >= 3);
      settle();
      if (i < 4) begin
        chk1("lk_cmd_valid", dtcm_cmd_valid, 1'b1);
        chkw("lk_addr", 32'(dtcm_cmd_addr), 32'h8);
        chk1("lk_read", dtcm_cmd_read, 1'b0);
        chkw("lk_wdata", dtcm_cmd_wdata, 32'hDEAD_BEEF);
        chkw("lk_wmask", 32'(dtcm_cmd_wmask), 32'hF);
        chk1("lk_p0_cmd_ready", p0_cmd_ready, 1'b0);
        chk1("lk_p1_cmd_ready", p1_cmd_ready, (i == 3));
      end else begin
        chkw("lk_next_addr", 32'(dtcm_cmd_addr), 32'h4);
        chk1("lk_next_p0_ready", p0_cmd_ready, 1'b1);
        chk1("lk_next_p1_ready", p1_cmd_ready, 1'b0);
      end
    end
    tick(); req_v[0] = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = rd_of(16'h0008); settle();
    chk1("lk_rsp1_p1", p1_rsp_valid, 1'b1);
    chk1("lk_rsp1_p0", p0_rsp_valid, 1'b0);
    tick(); dtcm_rsp_rdata = rd_of(16'h0004); settle();
    chk1("lk_rsp2_p0", p0_rsp_valid, 1'b1);
    chk1("lk_rsp2_p1", p1_rsp_valid, 1'b0);
    tick(); idle_in(); settle();
    chk1("lk_idle_active", arb_active, 1'b0);

    // FIFO full with responses withheld
    tick(); req_v[0] = 1'b1; req_a[0] = 16'h0030; settle();
    chk1("full_c0_p0_ready", p0_cmd_ready, 1'b1);
    tick(); req_v[1] = 1'b1; req_a[1] = 16'h0034; settle();
    chkw("full_c1_addr", 32'(dtcm_cmd_addr), 32'h34);
    chk1("full_c1_p1_ready", p1_cmd_ready, 1'b1);
    chk1("full_c1_p0_ready", p0_cmd_ready, 1'b0);
    tick(); req_v[1] = 1'b0; settle();
    chk1("full_cmd_valid", dtcm_cmd_valid, 1'b0);
    chk1("full_p0_ready", p0_cmd_ready, 1'b0);
    chk1("full_p1_ready", p1_cmd_ready, 1'b0);
    tick(); dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = rd_of(16'h0030); settle();
    chk1("full_pop_rsp_valid", p0_rsp_valid, 1'b1);
    chk1("full_pop_cmd_valid", dtcm_cmd_valid, 1'b0);
    tick(); dtcm_rsp_valid = 1'b0; settle();
    chk1("full_resume_cmd_valid", dtcm_cmd_valid, 1'b1);
    chkw("full_resume_addr", 32'(dtcm_cmd_addr), 32'h30);
    chk1("full_resume_p0_ready", p0_cmd_ready, 1'b1);

    // Response backpressure on head ID 1
    for (int i = 0; i <= 2; i++) begin
      tick();
      req_v[0] = 1'b0;
      dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = rd_of(16'h0034);
      rsp_rdy[1] = (i == 2);
      settle();
      chk1("bp_p1_rsp_valid", p1_rsp_valid, 1'b1);
      chk1("bp_p0_rsp_valid", p0_rsp_valid, 1'b0);
      chk1("bp_dtcm_rsp_ready", dtcm_rsp_ready, (i == 2));
    end
    tick(); rsp_rdy[1] = 1'b1; dtcm_rsp_rdata = rd_of(16'h0030); settle();
    chk1("bp_after_p0", p0_rsp_valid, 1'b1);
    chk1("bp_after_p1", p1_rsp_valid, 1'b0);
    tick(); idle_in(); settle();
    chk1("bp_idle_active", arb_active, 1'b0);

    // Stray response with an empty FIFO
    tick(); dtcm_rsp_valid = 1'b1; settle();
    chk1("stray_rsp_ready", dtcm_rsp_ready, 1'b1);
    chk1("stray_p0_rsp_valid", p0_rsp_valid, 1'b0);
    chk1("stray_p1_rsp_valid", p1_rsp_valid, 1'b0);
    chk1("stray_err_same_cycle", arb_err, 1'b0);
    tick(); dtcm_rsp_valid = 1'b0; settle();
    chk1("stray_err_set", arb_err, 1'b1);
    tick(); tick(); settle();
    chk1("stray_err_sticky", arb_err, 1'b1);
    tick(); rst = 1'b1; tick(); rst = 1'b0; settle();
    chk1("stray_err_cleared", arb_err, 1'b0);

    // Randomized traffic against the queue model
    prio_m = 0; lock_m = -1; rsp_done = 1'b0;
    done_v[0] = 1'b0; done_v[1] = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (done_v[n]) begin
          req_v[n] = 1'b0;
          done_v[n] = 1'b0;
        end
        if (!req_v[n] && cyc < 580 && ($urandom % 3) == 0) begin
          req_v[n]  = 1'b1;
          req_a[n]  = AW'($urandom);
          req_rd[n] = 1'($urandom);
          req_wd[n] = $urandom;
          req_wm[n] = 4'($urandom);
        end
        rsp_rdy[n] = (($urandom % 4) != 0);
      end
      if (rsp_done) begin
        dtcm_rsp_valid = 1'b0;
        rsp_done = 1'b0;
      end
      if (!dtcm_rsp_valid && q_dtcm.size() > 0 && ($urandom % 2) == 0) begin
        dtcm_rsp_valid = 1'b1;
        dtcm_rsp_rdata = rd_of(q_dtcm[0]);
      end
      dtcm_cmd_ready = (($urandom % 3) != 0);
      settle();

      if (lock_m >= 0) g = lock_m;
      else if (req_v[0] && req_v[1]) g = prio_m;
      else if (req_v[0]) g = 0;
      else if (req_v[1]) g = 1;
      else g = -1;
      iss = (g >= 0) && (q_out.size() < OUTS);
      chk1("r_cmd_valid", dtcm_cmd_valid, iss);
      chk1("r_p0_cmd_ready", p0_cmd_ready, iss && dtcm_cmd_ready && g == 0);
      chk1("r_p1_cmd_ready", p1_cmd_ready, iss && dtcm_cmd_ready && g == 1);
      if (iss) begin
        chkw("r_addr", 32'(dtcm_cmd_addr), 32'(req_a[g]));
        chk1("r_read", dtcm_cmd_read, req_rd[g]);
        chkw("r_wdata", dtcm_cmd_wdata, req_wd[g]);
        chkw("r_wmask", 32'(dtcm_cmd_wmask), 32'(req_wm[g]));
      end
      h = (q_out.size() > 0) ? q_out[0] : -1;
      exp_rr = (h < 0) ? 1'b1 : rsp_rdy[h];
      chk1("r_p0_rsp_valid", p0_rsp_valid, dtcm_rsp_valid && h == 0);
      chk1("r_p1_rsp_valid", p1_rsp_valid, dtcm_rsp_valid && h == 1);
      chk1("r_dtcm_rsp_ready", dtcm_rsp_ready, exp_rr);
      chk1("r_arb_active", arb_active, req_v[0] || req_v[1] || q_out.size() > 0);
      chk1("r_arb_err", arb_err, 1'b0);

      if (h >= 0 && dtcm_rsp_valid && exp_rr) begin
        if (h == 0) begin
          fa = pq0.pop_front();
        end else begin
          fa = pq1.pop_front();
        end
        chkw("r_rsp_rdata", (h == 0) ? p0_rsp_rdata : p1_rsp_rdata, rd_of(fa));
        void'(q_out.pop_front());
        void'(q_dtcm.pop_front());
        rsp_done = 1'b1;
      end
      if (iss && dtcm_cmd_ready) begin
        q_out.push_back(g);
        q_dtcm.push_back(req_a[g]);
        if (g == 0) pq0.push_back(req_a[0]);
        else pq1.push_back(req_a[1]);
        prio_m = 1 - g;
        lock_m = -1;
        done_v[g] = 1'b1;
      end else if (iss) begin
        lock_m = g;
      end
    end
    tick(); idle_in(); settle();
    chk1("r_end_active", arb_active, (q_out.size() > 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
